// File: rtl/sobel_frame_sched.sv
// Frame-level scheduler for the Sobel datapath: row fetch, core sequencing and write-back.
// Optional build macro SOBEL_SCHED_PERF_EN adds busy/stall performance counters.

module sobel_burst_issuer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int CNT_WIDTH      = 12,
    parameter int MAX_BURST      = 256,
    parameter int BYTES_PER_BEAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [CNT_WIDTH-1:0]  load_beats,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len
);
    logic [CNT_WIDTH-1:0] rem_q;
    logic [CNT_WIDTH-1:0] burst;

    assign burst   = (rem_q > CNT_WIDTH'(MAX_BURST)) ? CNT_WIDTH'(MAX_BURST) : rem_q;
    assign cmd_len = cmd_valid ? 8'(burst - 1'b1) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            rem_q     <= '0;
        end else if (load) begin
            cmd_valid <= (load_beats != '0);
            cmd_addr  <= load_addr;
            rem_q     <= load_beats;
        end else if (cmd_valid && cmd_ready) begin
            cmd_addr  <= cmd_addr + ADDR_WIDTH'(burst) * ADDR_WIDTH'(BYTES_PER_BEAT);
            rem_q     <= rem_q - burst;
            cmd_valid <= (rem_q != burst);
        end
    end
endmodule

module sobel_frame_sched #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DIM_WIDTH      = 12,
    parameter int MAX_BURST      = 256,
    parameter int BYTES_PER_BEAT = 4
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_areset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_src_base,
    input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [DIM_WIDTH-1:0]  cfg_width,
    input  logic [DIM_WIDTH-1:0]  cfg_height,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [7:0]            rd_cmd_len,
    input  logic                  rd_row_done,
    output logic [1:0]            lb_wr_sel,
    output logic                  core_start,
    output logic [1:0]            core_top_sel,
    input  logic                  core_done,
    output logic                  wr_cmd_valid,
    input  logic                  wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [7:0]            wr_cmd_len,
    input  logic                  wr_row_done
`ifdef SOBEL_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stall
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_COMPUTE, S_OVERLAP, S_DONE} state_t;

    logic clk, rst;
    assign clk = s00_axi_aclk;
    assign rst = s00_axi_areset;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] stride_q, rd_row_addr_q, wr_row_addr_q;
    logic [DIM_WIDTH-1:0]  height_q, row_beats_q, r_out_q;
    logic [1:0]            prime_cnt_q, lb_wr_sel_q, top_sel_q;
    logic                  rd_active_q, wr_active_q, core_start_q, cfg_err_q;

    logic                  cfg_ok, start_ok, rd_done_ev, wr_done_ev, core_done_ev;
    logic                  fetch_need, last_row, ov_exit;
    logic                  rd_load, wr_load;
    logic [ADDR_WIDTH-1:0] rd_load_addr;
    logic [DIM_WIDTH-1:0]  rd_load_beats;

    assign cfg_ok   = (cfg_width % DIM_WIDTH'(BYTES_PER_BEAT) == '0) &&
                      (cfg_width >= DIM_WIDTH'(BYTES_PER_BEAT)) &&
                      (cfg_height >= DIM_WIDTH'(3));
    assign start_ok = (state_q == S_IDLE) && start && cfg_ok;

    // Completion pulses only count while the matching row is outstanding; the
    // active flag clearing is the sticky capture, so arrival order is irrelevant.
    assign rd_done_ev   = rd_row_done && rd_active_q;
    assign wr_done_ev   = wr_row_done && wr_active_q;
    assign core_done_ev = core_done && (state_q == S_COMPUTE) && !core_start_q;
    assign fetch_need   = ({1'b0, r_out_q} + (DIM_WIDTH+1)'(3)) <= {1'b0, height_q};
    assign last_row     = (r_out_q == height_q - DIM_WIDTH'(2));
    assign ov_exit      = (state_q == S_OVERLAP) && (!rd_active_q || rd_done_ev) &&
                          (!wr_active_q || wr_done_ev);

    always_comb begin
        state_d       = state_q;
        rd_load       = 1'b0;
        wr_load       = 1'b0;
        rd_load_addr  = rd_row_addr_q + stride_q;
        rd_load_beats = row_beats_q;
        case (state_q)
            S_IDLE: if (start_ok) begin
                state_d       = S_PRIME;
                rd_load       = 1'b1;
                rd_load_addr  = cfg_src_base;
                rd_load_beats = cfg_width / DIM_WIDTH'(BYTES_PER_BEAT);
            end
            S_PRIME: if (rd_done_ev) begin
                if (prime_cnt_q == 2'd2) state_d = S_COMPUTE;
                else                     rd_load = 1'b1;
            end
            S_COMPUTE: if (core_done_ev) begin
                state_d = S_OVERLAP;
                wr_load = 1'b1;
                rd_load = fetch_need;
            end
            S_OVERLAP: if (ov_exit) state_d = last_row ? S_DONE : S_COMPUTE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q      <= '0;
            rd_row_addr_q <= '0;
            wr_row_addr_q <= '0;
            height_q      <= '0;
            row_beats_q   <= '0;
            r_out_q       <= '0;
            prime_cnt_q   <= '0;
            lb_wr_sel_q   <= '0;
            top_sel_q     <= '0;
            rd_active_q   <= 1'b0;
            wr_active_q   <= 1'b0;
            core_start_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            cfg_err_q    <= (state_q == S_IDLE) && start && !cfg_ok;
            core_start_q <= 1'b0;
            if (rd_load) rd_row_addr_q <= rd_load_addr;
            case (state_q)
                S_IDLE: if (start_ok) begin
                    stride_q      <= cfg_stride;
                    height_q      <= cfg_height;
                    row_beats_q   <= rd_load_beats;
                    wr_row_addr_q <= cfg_dst_base + cfg_stride;
                    r_out_q       <= DIM_WIDTH'(1);
                    prime_cnt_q   <= '0;
                    lb_wr_sel_q   <= '0;
                    top_sel_q     <= '0;
                    rd_active_q   <= 1'b1;
                    wr_active_q   <= 1'b0;
                end
                S_PRIME: if (rd_done_ev) begin
                    if (prime_cnt_q == 2'd2) begin
                        rd_active_q  <= 1'b0;
                        core_start_q <= 1'b1;
                    end else begin
                        prime_cnt_q <= prime_cnt_q + 2'd1;
                        lb_wr_sel_q <= lb_wr_sel_q + 2'd1;
                    end
                end
                S_COMPUTE: if (core_done_ev) begin
                    // The window's top row is no longer needed, so its buffer takes the next fetch.
                    wr_active_q <= 1'b1;
                    rd_active_q <= fetch_need;
                    if (fetch_need) lb_wr_sel_q <= top_sel_q;
                end
                S_OVERLAP: begin
                    if (rd_done_ev) rd_active_q <= 1'b0;
                    if (wr_done_ev) wr_active_q <= 1'b0;
                    if (ov_exit) begin
                        r_out_q       <= r_out_q + DIM_WIDTH'(1);
                        wr_row_addr_q <= wr_row_addr_q + stride_q;
                        top_sel_q     <= (top_sel_q == 2'd2) ? 2'd0 : top_sel_q + 2'd1;
                        core_start_q  <= !last_row;
                    end
                end
                default: ;
            endcase
        end
    end

    sobel_burst_issuer #(
        .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(DIM_WIDTH),
        .MAX_BURST(MAX_BURST), .BYTES_PER_BEAT(BYTES_PER_BEAT)
    ) u_rd (
        .clk(clk), .rst(rst), .load(rd_load), .load_addr(rd_load_addr),
        .load_beats(rd_load_beats), .cmd_valid(rd_cmd_valid), .cmd_ready(rd_cmd_ready),
        .cmd_addr(rd_cmd_addr), .cmd_len(rd_cmd_len)
    );

    sobel_burst_issuer #(
        .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(DIM_WIDTH),
        .MAX_BURST(MAX_BURST), .BYTES_PER_BEAT(BYTES_PER_BEAT)
    ) u_wr (
        .clk(clk), .rst(rst), .load(wr_load), .load_addr(wr_row_addr_q),
        .load_beats(row_beats_q), .cmd_valid(wr_cmd_valid), .cmd_ready(wr_cmd_ready),
        .cmd_addr(wr_cmd_addr), .cmd_len(wr_cmd_len)
    );

    assign busy         = (state_q == S_PRIME) || (state_q == S_COMPUTE) || (state_q == S_OVERLAP);
    assign done         = (state_q == S_DONE);
    assign cfg_err      = cfg_err_q;
    assign lb_wr_sel    = lb_wr_sel_q;
    assign core_start   = core_start_q;
    assign core_top_sel = top_sel_q;

`ifdef SOBEL_SCHED_PERF_EN
    logic stall;
    assign stall = (rd_cmd_valid && !rd_cmd_ready) || (wr_cmd_valid && !wr_cmd_ready);

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && perf_cycles != '1)  perf_cycles <= perf_cycles + 32'd1;
            if (stall && perf_stall != '1)  perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sobel_frame_sched.sv
// Self-checking bench for sobel_frame_sched: table of frames, random frames, stall and reset sequences.
module tb_sobel_frame_sched;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] cfg_src_base, cfg_dst_base, cfg_stride;
    logic [11:0] cfg_width, cfg_height;
    logic        busy, done, cfg_err;
    logic        rd_cmd_valid, rd_cmd_ready, rd_row_done;
    logic [31:0] rd_cmd_addr, wr_cmd_addr;
    logic [7:0]  rd_cmd_len, wr_cmd_len;
    logic [1:0]  lb_wr_sel, core_top_sel;
    logic        core_start, core_done;
    logic        wr_cmd_valid, wr_cmd_ready, wr_row_done;
`ifdef SOBEL_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    always #5 clk = ~clk;

    sobel_frame_sched dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst), .start(start),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_stride(cfg_stride),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_len(rd_cmd_len), .rd_row_done(rd_row_done), .lb_wr_sel(lb_wr_sel),
        .core_start(core_start), .core_top_sel(core_top_sel), .core_done(core_done),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_len(wr_cmd_len), .wr_row_done(wr_row_done)
`ifdef SOBEL_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Environment model: memory and core answer each completed row after a delay.
    int cyc = 0, rd_delay = 5, wr_delay = 5, core_delay = 3, rd_hold_until = 0;
    bit rnd_ready = 0;
    int cur_beats = 4, rd_acc = 0, wr_acc = 0, done_cnt = 0, err_cnt = 0;
    int rd_due[$], wr_due[$], core_due[$];
    logic [31:0] got_rd_addr[$], got_wr_addr[$];
    logic [7:0]  got_rd_len[$], got_wr_len[$];
    logic [1:0]  got_sel[$], got_top[$];

    initial begin : responder
        rd_cmd_ready = 0; wr_cmd_ready = 0; rd_row_done = 0; wr_row_done = 0; core_done = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rd_due.delete(); wr_due.delete(); core_due.delete();
                rd_acc = 0; wr_acc = 0;
                rd_row_done = 0; wr_row_done = 0; core_done = 0;
                rd_cmd_ready = 0; wr_cmd_ready = 0;
                continue;
            end
            rd_row_done = (rd_due.size() > 0 && rd_due[0] == cyc);
            if (rd_row_done) void'(rd_due.pop_front());
            wr_row_done = (wr_due.size() > 0 && wr_due[0] == cyc);
            if (wr_row_done) void'(wr_due.pop_front());
            core_done = (core_due.size() > 0 && core_due[0] == cyc);
            if (core_done) void'(core_due.pop_front());
            rd_cmd_ready = (cyc >= rd_hold_until) && (!rnd_ready || $urandom_range(0, 1) == 1);
            wr_cmd_ready = !rnd_ready || ($urandom_range(0, 1) == 1);
            if (rd_cmd_valid && rd_cmd_ready) begin
                got_rd_addr.push_back(rd_cmd_addr); got_rd_len.push_back(rd_cmd_len);
                got_sel.push_back(lb_wr_sel);
                rd_acc += int'(rd_cmd_len) + 1;
                if (rd_acc >= cur_beats) begin rd_acc = 0; rd_due.push_back(cyc + rd_delay); end
            end
            if (wr_cmd_valid && wr_cmd_ready) begin
                got_wr_addr.push_back(wr_cmd_addr); got_wr_len.push_back(wr_cmd_len);
                wr_acc += int'(wr_cmd_len) + 1;
                if (wr_acc >= cur_beats) begin wr_acc = 0; wr_due.push_back(cyc + wr_delay); end
            end
            if (core_start) begin
                got_top.push_back(core_top_sel);
                core_due.push_back(cyc + core_delay);
            end
            if (done) done_cnt++;
            if (cfg_err) err_cnt++;
        end
    end

    // Reference: every row split into <=256-beat bursts; row k lands in buffer k%3.
    logic [31:0] exp_rd_addr[$], exp_wr_addr[$];
    logic [7:0]  exp_rd_len[$], exp_wr_len[$];
    logic [1:0]  exp_sel[$], exp_top[$];

    task automatic build_model(input int w, input int h, input logic [31:0] src,
                               input logic [31:0] dst, input logic [31:0] stride);
        exp_rd_addr.delete(); exp_rd_len.delete(); exp_sel.delete();
        exp_wr_addr.delete(); exp_wr_len.delete(); exp_top.delete();
        for (int r = 0; r < h; r++) begin
            logic [31:0] a;
            int rem, n;
            a = src + 32'(r) * stride;
            rem = w / 4;
            while (rem > 0) begin
                n = (rem > 256) ? 256 : rem;
                exp_rd_addr.push_back(a); exp_rd_len.push_back(8'(n - 1)); exp_sel.push_back(2'(r % 3));
                a += 32'(n * 4); rem -= n;
            end
            if (r >= 1 && r <= h - 2) begin
                a = dst + 32'(r) * stride;
                rem = w / 4;
                while (rem > 0) begin
                    n = (rem > 256) ? 256 : rem;
                    exp_wr_addr.push_back(a); exp_wr_len.push_back(8'(n - 1));
                    a += 32'(n * 4); rem -= n;
                end
                exp_top.push_back(2'((r - 1) % 3));
            end
        end
    endtask

    task automatic kick(input int w, input int h, input logic [31:0] src,
                        input logic [31:0] dst, input logic [31:0] stride);
        got_rd_addr.delete(); got_rd_len.delete(); got_sel.delete();
        got_wr_addr.delete(); got_wr_len.delete(); got_top.delete();
        done_cnt = 0; err_cnt = 0; cur_beats = w / 4;
        cfg_width = 12'(w); cfg_height = 12'(h);
        cfg_src_base = src; cfg_dst_base = dst; cfg_stride = stride;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic finish_frame(input string tag, input int w, input int h, input logic [31:0] src,
                                input logic [31:0] dst, input logic [31:0] stride);
        int t = 0;
        while (done_cnt == 0 && t < 20000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        build_model(w, h, src, dst, stride);
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " cfg_err_cnt"}, err_cnt, 0);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " rd_count"}, got_rd_addr.size(), exp_rd_addr.size());
        check({tag, " wr_count"}, got_wr_addr.size(), exp_wr_addr.size());
        check({tag, " core_count"}, got_top.size(), exp_top.size());
        for (int i = 0; i < got_rd_addr.size() && i < exp_rd_addr.size(); i++)
            check($sformatf("%s rd[%0d] addr/len/sel", tag, i),
                  {got_rd_addr[i], got_rd_len[i], got_sel[i]}, {exp_rd_addr[i], exp_rd_len[i], exp_sel[i]});
        for (int i = 0; i < got_wr_addr.size() && i < exp_wr_addr.size(); i++)
            check($sformatf("%s wr[%0d] addr/len", tag, i),
                  {got_wr_addr[i], got_wr_len[i]}, {exp_wr_addr[i], exp_wr_len[i]});
        for (int i = 0; i < got_top.size() && i < exp_top.size(); i++)
            check($sformatf("%s top[%0d]", tag, i), got_top[i], exp_top[i]);
    endtask

    function automatic logic [127:0] all_outs();
        return {busy, done, cfg_err, rd_cmd_valid, rd_cmd_addr, rd_cmd_len, lb_wr_sel,
                core_start, core_top_sel, wr_cmd_valid, wr_cmd_addr, wr_cmd_len};
    endfunction

    typedef struct {
        int w, h;
        logic [31:0] src, dst, stride;
        int rdd, wrd;
        bit rnd, bad;
    } vec_t;

    vec_t tbl[9];

    initial begin : main
        tbl[0] = '{16,   4, 32'h1000,     32'h8000,   32'h40,  5, 5, 0, 0};
        tbl[1] = '{2048, 3, 32'h0,        32'h100000, 32'h800, 4, 4, 0, 0};
        tbl[2] = '{1032, 4, 32'h20000,    32'h40000,  32'h500, 3, 6, 0, 0};
        tbl[3] = '{16,   2, 32'h1000,     32'h8000,   32'h40,  5, 5, 0, 1};
        tbl[4] = '{6,    4, 32'h1000,     32'h8000,   32'h40,  5, 5, 0, 1};
        tbl[5] = '{16,   4, 32'h1000,     32'h8000,   32'h40,  8, 5, 0, 0};
        tbl[6] = '{16,   4, 32'h1000,     32'h8000,   32'h40,  5, 5, 0, 0};
        tbl[7] = '{16,   5, 32'hFFFFFF80, 32'hFFFFFFC0, 32'h40, 2, 3, 1, 0};
        tbl[8] = '{4,    6, 32'h300,      32'h900,    32'h10,  1, 1, 1, 0};

        rst = 1; start = 0;
        cfg_src_base = 0; cfg_dst_base = 0; cfg_stride = 0; cfg_width = 0; cfg_height = 0;
        repeat (3) @(negedge clk);
        check("reset outputs", all_outs(), 0);
        rst = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            rd_delay = tbl[i].rdd; wr_delay = tbl[i].wrd; rnd_ready = tbl[i].rnd;
            kick(tbl[i].w, tbl[i].h, tbl[i].src, tbl[i].dst, tbl[i].stride);
            if (tbl[i].bad) begin
                repeat (5) @(negedge clk);
                check($sformatf("tbl%0d cfg_err_cnt", i), err_cnt, 1);
                check($sformatf("tbl%0d busy", i), busy, 0);
                check($sformatf("tbl%0d cmds", i), got_rd_addr.size() + got_wr_addr.size(), 0);
            end else begin
                finish_frame($sformatf("tbl%0d", i), tbl[i].w, tbl[i].h, tbl[i].src, tbl[i].dst, tbl[i].stride);
            end
        end

        for (int i = 0; i < 6; i++) begin
            int w, h;
            logic [31:0] s, d, st;
            w = 4 * $urandom_range(1, 300); h = $urandom_range(3, 7);
            s = $urandom; d = $urandom; st = $urandom_range(0, 32'h3000);
            rd_delay = $urandom_range(1, 6); wr_delay = $urandom_range(1, 6); rnd_ready = 1;
            kick(w, h, s, d, st);
            finish_frame($sformatf("rnd%0d", i), w, h, s, d, st);
        end

        // Read command held off for 10 cycles while a second (invalid) start arrives.
        rnd_ready = 0; rd_delay = 5; wr_delay = 5;
        rd_hold_until = cyc + 1000;
        kick(16, 4, 32'h2000, 32'h9000, 32'h80);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall[%0d] rd cmd", i), {rd_cmd_valid, rd_cmd_addr, rd_cmd_len},
                  {1'b1, 32'h2000, 8'd3});
            if (i == 3) begin cfg_width = 12'd6; start = 1; end
            else if (i == 4) begin cfg_width = 12'd16; start = 0; end
            @(negedge clk);
        end
        rd_hold_until = 0;
        finish_frame("stall", 16, 4, 32'h2000, 32'h9000, 32'h80);

        // Reset in the middle of a frame.
        kick(16, 8, 32'h4000, 32'hA000, 32'h40);
        repeat (30) @(negedge clk);
        check("midframe busy", busy, 1);
        rst = 1;
        @(negedge clk);
        check("midframe reset outputs", all_outs(), 0);
        rst = 0;
        repeat (60) @(negedge clk);
        check("midframe no done", done_cnt, 0);
        check("midframe idle", busy, 0);
        kick(16, 4, 32'h1000, 32'h8000, 32'h40);
        finish_frame("post_reset", 16, 4, 32'h1000, 32'h8000, 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
